// File: rtl/ysyx_22040237_lsu_if.sv
// Bundle between the LSU and its surroundings: execute-stage request, memory port, write-back.
// The master modport is the LSU itself; slave is the execute/memory/write-back side.
interface ysyx_22040237_lsu_if;
    logic        ls_valid_i;
    logic        ls_ready_o;
    logic [6:0]  ls_info_bus_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic        rd_wr_en_i;
    logic [4:0]  rd_idx_i;

    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic        mem_req_wen_o;
    logic [63:0] mem_req_addr_o;
    logic [63:0] mem_req_wdata_o;
    logic [7:0]  mem_req_wmask_o;
    logic        mem_rsp_valid_i;
    logic [63:0] mem_rsp_rdata_i;

    logic        wb_valid_o;
    logic        wb_rd_wr_en_o;
    logic [4:0]  wb_rd_idx_o;
    logic [63:0] wb_data_o;
    logic [1:0]  err_code_o;

    modport master (
        input  ls_valid_i, ls_info_bus_i, addr_i, wdata_i, rd_wr_en_i, rd_idx_i,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
        output ls_ready_o,
        output mem_req_valid_o, mem_req_wen_o, mem_req_addr_o, mem_req_wdata_o, mem_req_wmask_o,
        output wb_valid_o, wb_rd_wr_en_o, wb_rd_idx_o, wb_data_o, err_code_o
    );

    modport slave (
        output ls_valid_i, ls_info_bus_i, addr_i, wdata_i, rd_wr_en_i, rd_idx_i,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
        input  ls_ready_o,
        input  mem_req_valid_o, mem_req_wen_o, mem_req_addr_o, mem_req_wdata_o, mem_req_wmask_o,
        input  wb_valid_o, wb_rd_wr_en_o, wb_rd_idx_o, wb_data_o, err_code_o
    );
endinterface

// File: rtl/ysyx_22040237_lsu.sv
// Multi-cycle load/store unit: one aligned 64-bit memory access in flight, sized and
// extended load data returned to write-back, misalignment and response timeout reported.
module ysyx_22040237_lsu #(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    ysyx_22040237_lsu_if.master bus
);
    localparam int CNT_W = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT + 1);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic               load_q, store_q, usign_q;
    logic [1:0]         size_q;
    logic [2:0]         off_q;
    logic [60:0]        addr_hi_q;
    logic [63:0]        wdata_q;
    logic [7:0]         wmask_q;
    logic               rd_wr_en_q;
    logic [4:0]         rd_idx_q;
    logic [63:0]        rdata_q, rdata_d;
    logic [1:0]         err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [6:0]         info;
    logic               accept;
    logic [1:0]         size_in;
    logic [3:0]         size_bytes;
    logic [2:0]         off_in;
    logic               misaligned_in;
    logic [7:0]         wmask_in;
    logic [63:0]        wdata_in;

    assign info   = bus.ls_info_bus_i;
    assign accept = bus.ls_valid_i & bus.ls_ready_o;
    assign off_in = bus.addr_i[2:0];

    // size_in is log2 of the access width in bytes
    always_comb begin
        if (info[6])      size_in = 2'd3;
        else if (info[5]) size_in = 2'd2;
        else if (info[4]) size_in = 2'd1;
        else              size_in = 2'd0;
    end

    assign size_bytes    = 4'd1 << size_in;
    assign misaligned_in = (off_in & ((3'd1 << size_in) - 3'd1)) != 3'd0;
    assign wdata_in      = bus.wdata_i << {off_in, 3'b000};

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign wmask_in[gi] = info[1]
                            & (4'(gi) >= {1'b0, off_in})
                            & (4'(gi) < ({1'b0, off_in} + size_bytes));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            load_q     <= 1'b0;
            store_q    <= 1'b0;
            usign_q    <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
            addr_hi_q  <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rd_wr_en_q <= 1'b0;
            rd_idx_q   <= '0;
            rdata_q    <= '0;
            err_q      <= ERR_NONE;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                load_q     <= info[0];
                store_q    <= info[1];
                usign_q    <= info[2];
                size_q     <= size_in;
                off_q      <= off_in;
                addr_hi_q  <= bus.addr_i[63:3];
                wdata_q    <= wdata_in;
                wmask_q    <= wmask_in;
                rd_wr_en_q <= bus.rd_wr_en_i;
                rd_idx_q   <= bus.rd_idx_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (misaligned_in || !(info[0] || info[1])) begin
                        state_d = S_RESP;
                        err_d   = misaligned_in ? ERR_MISALIGN : ERR_NONE;
                    end else begin
                        state_d = S_REQ;
                        err_d   = ERR_NONE;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready_i) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // A response arriving in the last allowed cycle still beats the timeout
                if (bus.mem_rsp_valid_i) begin
                    rdata_d = bus.mem_rsp_rdata_i;
                    state_d = S_RESP;
                end else if (int'(cnt_q) + 1 >= RSP_TIMEOUT) begin
                    state_d = S_RESP;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic [63:0] lane_data;
    logic [63:0] ext_data;
    logic        in_req;
    logic        in_resp;
    logic        err_none;

    assign lane_data = rdata_q >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    ext_data = usign_q ? {56'd0, lane_data[7:0]}
                                        : {{56{lane_data[7]}}, lane_data[7:0]};
            2'd1:    ext_data = usign_q ? {48'd0, lane_data[15:0]}
                                        : {{48{lane_data[15]}}, lane_data[15:0]};
            2'd2:    ext_data = usign_q ? {32'd0, lane_data[31:0]}
                                        : {{32{lane_data[31]}}, lane_data[31:0]};
            default: ext_data = lane_data;
        endcase
    end

    assign in_req   = (state_q == S_REQ);
    assign in_resp  = (state_q == S_RESP);
    assign err_none = (err_q == ERR_NONE);

    // rst gates ready combinationally so nothing is accepted while reset is held
    assign bus.ls_ready_o      = (state_q == S_IDLE) & ~rst;
    assign bus.mem_req_valid_o = in_req;
    assign bus.mem_req_wen_o   = in_req & store_q;
    assign bus.mem_req_addr_o  = in_req ? {addr_hi_q, 3'b000} : '0;
    assign bus.mem_req_wdata_o = in_req ? wdata_q : '0;
    assign bus.mem_req_wmask_o = in_req ? wmask_q : '0;

    assign bus.wb_valid_o      = in_resp;
    assign bus.wb_rd_wr_en_o   = in_resp & load_q & rd_wr_en_q & err_none;
    assign bus.wb_rd_idx_o     = in_resp ? rd_idx_q : '0;
    assign bus.wb_data_o       = (in_resp & load_q & ~store_q & err_none) ? ext_data : '0;
    assign bus.err_code_o      = in_resp ? err_q : ERR_NONE;
endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// Self-checking bench for ysyx_22040237_lsu: directed corner cases plus randomized
// transactions compared against a byte-level arithmetic model.
module tb_ysyx_22040237_lsu;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ysyx_22040237_lsu_if bus();

    ysyx_22040237_lsu #(.RSP_TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          accepted;
        bit          req_seen;
        logic [63:0] req_addr;
        logic [63:0] req_wdata;
        logic [7:0]  req_wmask;
        logic        req_wen;
        bit          req_stable;
        bit          busy_ok;
        bit          wb_seen;
        int          wb_cycles;
        logic        wb_rd_wr_en;
        logic [4:0]  wb_rd_idx;
        logic [63:0] wb_data;
        logic [1:0]  err;
        logic        wb_after;
        logic        ready_after;
    } obs_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [6:0] info);
        if (info[6]) return 8;
        if (info[5]) return 4;
        if (info[4]) return 2;
        return 1;
    endfunction

    function automatic bit m_misal(input logic [6:0] info, input logic [63:0] addr);
        return (int'(addr[2:0]) % m_size(info)) != 0;
    endfunction

    function automatic logic [63:0] m_load(input logic [6:0] info, input logic [63:0] addr,
                                           input logic [63:0] rdata);
        int sz;
        int off;
        logic [63:0] v;
        logic [63:0] mask;
        sz   = m_size(info);
        off  = int'(addr[2:0]);
        v    = rdata >> (8 * off);
        mask = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
        v    = v & mask;
        if (!info[2] && sz < 8 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- transaction driver / memory responder ----------------
    task automatic run_txn(input logic [6:0] info, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic rd_wr_en, input logic [4:0] rd_idx, input int ready_delay,
                           input int rsp_delay, input logic [63:0] rdata, input bit stray,
                           output obs_t o);
        int n;
        int req_cycles;
        int wait_idx;
        bit in_wait;
        o = '{default: '0};
        n = 0;
        while (!bus.ls_ready_o && n < 20) begin
            step();
            n++;
        end
        o.accepted = bus.ls_ready_o;
        if (!o.accepted) return;
        bus.ls_valid_i    = 1'b1;
        bus.ls_info_bus_i = info;
        bus.addr_i        = addr;
        bus.wdata_i       = wdata;
        bus.rd_wr_en_i    = rd_wr_en;
        bus.rd_idx_i      = rd_idx;
        step();
        bus.ls_valid_i    = 1'b0;
        bus.ls_info_bus_i = 7'($urandom);
        bus.addr_i        = {$urandom, $urandom};
        bus.wdata_i       = {$urandom, $urandom};
        bus.rd_wr_en_i    = 1'($urandom);
        bus.rd_idx_i      = 5'($urandom);
        o.req_stable = 1;
        o.busy_ok    = 1;
        req_cycles   = 0;
        wait_idx     = 0;
        in_wait      = 0;
        n            = 0;
        while (!o.wb_seen && n < 60) begin
            n++;
            if (bus.wb_valid_o) begin
                o.wb_seen     = 1;
                o.wb_cycles   = n;
                o.wb_rd_wr_en = bus.wb_rd_wr_en_o;
                o.wb_rd_idx   = bus.wb_rd_idx_o;
                o.wb_data     = bus.wb_data_o;
                o.err         = bus.err_code_o;
            end else begin
                if (bus.ls_ready_o) o.busy_ok = 0;
                if (bus.mem_req_valid_o) begin
                    if (!o.req_seen) begin
                        o.req_seen  = 1;
                        o.req_addr  = bus.mem_req_addr_o;
                        o.req_wdata = bus.mem_req_wdata_o;
                        o.req_wmask = bus.mem_req_wmask_o;
                        o.req_wen   = bus.mem_req_wen_o;
                    end else if (o.req_addr !== bus.mem_req_addr_o || o.req_wdata !== bus.mem_req_wdata_o ||
                                 o.req_wmask !== bus.mem_req_wmask_o || o.req_wen !== bus.mem_req_wen_o) begin
                        o.req_stable = 0;
                    end
                    bus.mem_req_ready_i = (req_cycles >= ready_delay);
                    bus.mem_rsp_valid_i = stray;
                    bus.mem_rsp_rdata_i = ~rdata;
                    req_cycles++;
                    step();
                    in_wait = bus.mem_req_ready_i;
                    bus.mem_req_ready_i = 1'b0;
                    bus.mem_rsp_valid_i = 1'b0;
                end else begin
                    if (in_wait) begin
                        bus.mem_rsp_valid_i = (wait_idx == rsp_delay);
                        bus.mem_rsp_rdata_i = rdata;
                        wait_idx++;
                    end
                    step();
                    bus.mem_rsp_valid_i = 1'b0;
                end
            end
        end
        if (o.wb_seen) begin
            step();
            o.wb_after    = bus.wb_valid_o;
            o.ready_after = bus.ls_ready_o;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.ls_valid_i = 1'b1;
        bus.ls_info_bus_i = 7'b1000001;
        bus.mem_rsp_valid_i = 1'b1;
        step();
        step();
        checks++; if (bus.ls_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ls_ready: got %b expected 0", bus.ls_ready_o); end
        checks++; if (bus.mem_req_valid_o !== 1'b0 || bus.mem_req_wen_o !== 1'b0 || bus.mem_req_wmask_o !== 8'h0)
            begin failures++; $display("FAIL reset_req_ctrl: got v=%b wen=%b mask=%h expected 0", bus.mem_req_valid_o, bus.mem_req_wen_o, bus.mem_req_wmask_o); end
        checks++; if (bus.mem_req_addr_o !== 64'h0 || bus.mem_req_wdata_o !== 64'h0)
            begin failures++; $display("FAIL reset_req_data: got addr=%h wdata=%h expected 0", bus.mem_req_addr_o, bus.mem_req_wdata_o); end
        checks++; if (bus.wb_valid_o !== 1'b0 || bus.wb_rd_wr_en_o !== 1'b0 || bus.wb_rd_idx_o !== 5'h0 || bus.wb_data_o !== 64'h0 || bus.err_code_o !== 2'h0)
            begin failures++; $display("FAIL reset_wb: got v=%b en=%b idx=%0d data=%h err=%0d expected 0", bus.wb_valid_o, bus.wb_rd_wr_en_o, bus.wb_rd_idx_o, bus.wb_data_o, bus.err_code_o); end
        bus.ls_valid_i = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        rst = 1'b0;
        step();
        checks++; if (bus.ls_ready_o !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b expected 1", bus.ls_ready_o); end
    endtask

    task automatic test_lb_lbu();
        obs_t o;
        run_txn(7'b0001001, 64'h1003, 64'h0, 1'b1, 5'd7, 0, 0, 64'h00000000_80000000, 1'b0, o);
        checks++; if (o.wb_data !== 64'hFFFF_FFFF_FFFF_FF80 || o.err !== 2'd0)
            begin failures++; $display("FAIL lb_data: got %h err=%0d expected ffffffffffffff80 err=0", o.wb_data, o.err); end
        checks++; if (o.wb_cycles !== 3 || o.wb_rd_wr_en !== 1'b1 || o.wb_rd_idx !== 5'd7)
            begin failures++; $display("FAIL lb_wb: got cyc=%0d en=%b idx=%0d expected cyc=3 en=1 idx=7", o.wb_cycles, o.wb_rd_wr_en, o.wb_rd_idx); end
        run_txn(7'b0001101, 64'h1003, 64'h0, 1'b1, 5'd8, 0, 0, 64'h00000000_80000000, 1'b0, o);
        checks++; if (o.wb_data !== 64'h80 || o.err !== 2'd0)
            begin failures++; $display("FAIL lbu_data: got %h err=%0d expected 80 err=0", o.wb_data, o.err); end
    endtask

    task automatic test_sw();
        obs_t o;
        run_txn(7'b0100010, 64'h1004, 64'h11223344_55667788, 1'b1, 5'd3, 0, 0, 64'h0, 1'b0, o);
        checks++; if (o.req_addr !== 64'h1000 || o.req_wmask !== 8'hF0 || o.req_wen !== 1'b1)
            begin failures++; $display("FAIL sw_req: got addr=%h mask=%h wen=%b expected 1000 f0 1", o.req_addr, o.req_wmask, o.req_wen); end
        checks++; if (o.req_wdata !== 64'h55667788_00000000)
            begin failures++; $display("FAIL sw_wdata: got %h expected 5566778800000000", o.req_wdata); end
        checks++; if (o.wb_rd_wr_en !== 1'b0 || o.wb_data !== 64'h0 || o.err !== 2'd0)
            begin failures++; $display("FAIL sw_wb: got en=%b data=%h err=%0d expected 0 0 0", o.wb_rd_wr_en, o.wb_data, o.err); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_txn(7'b0100001, 64'h1002, 64'h0, 1'b1, 5'd4, 0, 0, 64'h0, 1'b0, o);
        checks++; if (o.req_seen !== 1'b0) begin failures++; $display("FAIL lw_mis_req: got req_seen=%b expected 0", o.req_seen); end
        checks++; if (o.wb_cycles !== 1 || o.err !== 2'd1 || o.wb_rd_wr_en !== 1'b0)
            begin failures++; $display("FAIL lw_mis_wb: got cyc=%0d err=%0d en=%b expected 1 1 0", o.wb_cycles, o.err, o.wb_rd_wr_en); end
        checks++; if (o.wb_after !== 1'b0 || o.ready_after !== 1'b1)
            begin failures++; $display("FAIL lw_mis_pulse: got after=%b ready=%b expected 0 1", o.wb_after, o.ready_after); end
    endtask

    task automatic test_ready_stall();
        obs_t o;
        run_txn(7'b1000001, 64'h2008, 64'h0, 1'b1, 5'd9, 5, 0, 64'hDEAD_BEEF_0123_4567, 1'b1, o);
        checks++; if (o.req_stable !== 1'b1 || o.busy_ok !== 1'b1)
            begin failures++; $display("FAIL ld_stall_stable: got stable=%b busy_ok=%b expected 1 1", o.req_stable, o.busy_ok); end
        checks++; if (o.req_addr !== 64'h2008 || o.req_wmask !== 8'h00 || o.req_wen !== 1'b0)
            begin failures++; $display("FAIL ld_stall_req: got addr=%h mask=%h wen=%b expected 2008 00 0", o.req_addr, o.req_wmask, o.req_wen); end
        checks++; if (o.wb_cycles !== 8 || o.wb_data !== 64'hDEAD_BEEF_0123_4567 || o.err !== 2'd0)
            begin failures++; $display("FAIL ld_stall_wb: got cyc=%0d data=%h err=%0d expected 8 deadbeef01234567 0", o.wb_cycles, o.wb_data, o.err); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_txn(7'b1000001, 64'h3000, 64'h0, 1'b1, 5'd2, 0, 100, 64'h1234, 1'b0, o);
        checks++; if (o.wb_cycles !== 2 + T || o.err !== 2'd2)
            begin failures++; $display("FAIL timeout_wb: got cyc=%0d err=%0d expected %0d 2", o.wb_cycles, o.err, 2 + T); end
        checks++; if (o.wb_rd_wr_en !== 1'b0 || o.wb_data !== 64'h0)
            begin failures++; $display("FAIL timeout_data: got en=%b data=%h expected 0 0", o.wb_rd_wr_en, o.wb_data); end
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_rdata_i = 64'h1234;
        step();
        bus.mem_rsp_valid_i = 1'b0;
        checks++; if (bus.wb_valid_o !== 1'b0 || bus.ls_ready_o !== 1'b1)
            begin failures++; $display("FAIL timeout_late_rsp: got wb=%b ready=%b expected 0 1", bus.wb_valid_o, bus.ls_ready_o); end
        run_txn(7'b1000001, 64'h3000, 64'h0, 1'b1, 5'd2, 0, T - 1, 64'h5555, 1'b0, o);
        checks++; if (o.wb_cycles !== 2 + T || o.err !== 2'd0 || o.wb_data !== 64'h5555)
            begin failures++; $display("FAIL timeout_edge_rsp: got cyc=%0d err=%0d data=%h expected %0d 0 5555", o.wb_cycles, o.err, o.wb_data, 2 + T); end
    endtask

    task automatic test_rst_mid();
        bit no_wb;
        bus.ls_valid_i    = 1'b1;
        bus.ls_info_bus_i = 7'b1000001;
        bus.addr_i        = 64'h4000;
        bus.rd_wr_en_i    = 1'b1;
        bus.rd_idx_i      = 5'd5;
        step();
        bus.ls_valid_i      = 1'b0;
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        checks++; if (bus.ls_ready_o !== 1'b0 || bus.wb_valid_o !== 1'b0 || bus.mem_req_valid_o !== 1'b0)
            begin failures++; $display("FAIL rst_mid_hold: got ready=%b wb=%b req=%b expected 0 0 0", bus.ls_ready_o, bus.wb_valid_o, bus.mem_req_valid_o); end
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_rdata_i = 64'hAAAA;
        step();
        bus.mem_rsp_valid_i = 1'b0;
        rst = 1'b0;
        no_wb = 1;
        for (int k = 0; k < 3; k++) begin
            if (bus.wb_valid_o !== 1'b0) no_wb = 0;
            step();
        end
        checks++; if (no_wb !== 1'b1) begin failures++; $display("FAIL rst_mid_no_wb: got wb pulse expected none"); end
        checks++; if (bus.ls_ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_ready: got %b expected 1", bus.ls_ready_o); end
        bus.mem_rsp_valid_i = 1'b1;
        step();
        bus.mem_rsp_valid_i = 1'b0;
        checks++; if (bus.wb_valid_o !== 1'b0 || bus.ls_ready_o !== 1'b1)
            begin failures++; $display("FAIL idle_stray_rsp: got wb=%b ready=%b expected 0 1", bus.wb_valid_o, bus.ls_ready_o); end
    endtask

    task automatic test_random();
        obs_t o;
        for (int i = 0; i < 150; i++) begin
            logic [6:0]  info;
            logic [63:0] addr, wdata, rdata;
            logic        rwe;
            logic [4:0]  ridx;
            int op, sz, off, rdy, rsp, mi;
            bit mem;
            logic [1:0]  e_err;
            logic [63:0] e_data;
            op   = $urandom_range(0, 4);
            info = {4'($urandom), 1'($urandom), (op == 2 || op == 3), (op <= 1)};
            sz   = m_size(info);
            off  = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) off = off & ~(sz - 1);
            addr  = {$urandom, $urandom};
            addr[2:0] = 3'(off);
            wdata = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            rwe   = 1'($urandom);
            ridx  = 5'($urandom);
            rdy   = $urandom_range(0, 3);
            rsp   = $urandom_range(0, T + 1);
            run_txn(info, addr, wdata, rwe, ridx, rdy, rsp, rdata, 1'($urandom), o);
            mem   = !m_misal(info, addr) && (info[0] || info[1]);
            e_err = m_misal(info, addr) ? 2'd1 : (!mem ? 2'd0 : (rsp < T ? 2'd0 : 2'd2));
            e_data = (info[0] && e_err == 2'd0) ? m_load(info, addr, rdata) : 64'h0;
            checks++; if (o.wb_seen !== 1'b1 || o.wb_cycles !== (!mem ? 1 : (rsp < T ? 3 + rdy + rsp : 2 + rdy + T)))
                begin failures++; $display("FAIL rand_latency[%0d]: got seen=%b cyc=%0d expected mem=%b rdy=%0d rsp=%0d", i, o.wb_seen, o.wb_cycles, mem, rdy, rsp); end
            checks++; if (o.req_seen !== mem) begin failures++; $display("FAIL rand_req_seen[%0d]: got %b expected %b", i, o.req_seen, mem); end
            if (mem) begin
                mi = ((1 << sz) - 1) << off;
                checks++; if (o.req_addr !== (addr & ~64'h7) || o.req_wen !== info[1] || o.req_wmask !== (info[1] ? 8'(mi) : 8'h0))
                    begin failures++; $display("FAIL rand_req[%0d]: got addr=%h wen=%b mask=%h for addr=%h info=%b", i, o.req_addr, o.req_wen, o.req_wmask, addr, info); end
                checks++; if (o.req_wdata !== (wdata << (8 * off)))
                    begin failures++; $display("FAIL rand_wdata[%0d]: got %h expected %h", i, o.req_wdata, wdata << (8 * off)); end
                checks++; if (o.req_stable !== 1'b1) begin failures++; $display("FAIL rand_req_stable[%0d]: got 0 expected 1", i); end
            end
            checks++; if (o.busy_ok !== 1'b1) begin failures++; $display("FAIL rand_busy_ready[%0d]: got ready high mid-access expected low", i); end
            checks++; if (o.err !== e_err) begin failures++; $display("FAIL rand_err[%0d]: got %0d expected %0d", i, o.err, e_err); end
            checks++; if (o.wb_data !== e_data) begin failures++; $display("FAIL rand_data[%0d]: got %h expected %h", i, o.wb_data, e_data); end
            checks++; if (o.wb_rd_wr_en !== (info[0] & rwe & (e_err == 2'd0)) || o.wb_rd_idx !== ridx)
                begin failures++; $display("FAIL rand_rd[%0d]: got en=%b idx=%0d expected en=%b idx=%0d", i, o.wb_rd_wr_en, o.wb_rd_idx, info[0] & rwe & (e_err == 2'd0), ridx); end
            checks++; if (o.wb_after !== 1'b0 || o.ready_after !== 1'b1)
                begin failures++; $display("FAIL rand_pulse[%0d]: got after=%b ready=%b expected 0 1", i, o.wb_after, o.ready_after); end
        end
    endtask

    initial begin
        bus.ls_valid_i      = 1'b0;
        bus.ls_info_bus_i   = '0;
        bus.addr_i          = '0;
        bus.wdata_i         = '0;
        bus.rd_wr_en_i      = 1'b0;
        bus.rd_idx_i        = '0;
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_rdata_i = '0;
        test_reset();
        test_lb_lbu();
        test_sw();
        test_misaligned();
        test_ready_stall();
        test_timeout();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
